// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: stalls execute while busy and
// commits the remainder to HI and the quotient to LO one cycle after the last step.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             startE,
   input  logic             signedE,
   input  logic [WIDTH-1:0] opaE,
   input  logic [WIDTH-1:0] opbE,
   input  logic             cancelE,
   output logic             stall_divE,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             result_valid
);

   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dbz_q, dbz_d;
   logic             valid_q, valid_d;

   logic [WIDTH:0]   rem_sh, rem_diff;
   logic [WIDTH-1:0] rem_nx, quo_nx, mag_a, mag_b, quo_fix, rem_fix;

   // quo_q starts as the dividend magnitude; its MSBs feed the remainder while quotient bits enter at the LSB
   always_comb begin : step
      rem_sh   = {rem_q, quo_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, dvs_q};
      rem_nx   = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
      quo_nx   = {quo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
      quo_fix  = qneg_q ? -quo_nx : quo_nx;
      rem_fix  = rneg_q ? -rem_nx : rem_nx;
      mag_a    = (signedE && opaE[WIDTH-1]) ? -opaE : opaE;
      mag_b    = (signedE && opbE[WIDTH-1]) ? -opbE : opbE;
   end

   always_ff @(posedge clk) begin : state_reg
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         valid_q <= valid_d;
      end
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dbz_q  <= dbz_d;
   end

   always_comb begin : next_state
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dbz_d   = dbz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (startE && !cancelE) begin
               state_d = BUSY;
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = mag_a;
               dvs_d   = mag_b;
               qneg_d  = signedE && (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
               rneg_d  = signedE && opaE[WIDTH-1];
               dbz_d   = (opbE == '0);
            end
         end
         BUSY: begin
            if (cancelE) begin
               state_d = IDLE;
            end else begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  // a zero divisor leaves the dividend magnitude as remainder, so only LO needs forcing
                  state_d = DONE;
                  valid_d = 1'b1;
                  hi_d    = rem_fix;
                  lo_d    = dbz_q ? '1 : quo_fix;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin : outputs
      stall_divE   = ((state_q == IDLE && startE) || state_q == BUSY) && !cancelE && !rst;
      hi_o         = hi_q;
      lo_o         = lo_q;
      result_valid = valid_q;
   end

endmodule
